// File: rtl/display_pkg.sv
// Shared definitions for the RTC-to-VGA digit display path: FSM encoding,
// register-file entry indices and the BCD blanking value.
package display_pkg;

  localparam int N_REG_DEF = 9;

  // Byte shown in place of a corrupted BCD entry.
  localparam logic [7:0] BCD_BLANK = 8'h00;

  // FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESENTA = 2'd1;
  localparam logic [1:0] ST_STROBE   = 2'd2;
  localparam logic [1:0] ST_ESPERA   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    PRESENTA = ST_PRESENTA,
    STROBE   = ST_STROBE,
    ESPERA   = ST_ESPERA
  } state_t;

  // Entry positions inside DATOS_IN / POSICION
  localparam int IDX_SEG    = 0;
  localparam int IDX_MIN    = 1;
  localparam int IDX_HORA   = 2;
  localparam int IDX_DIA    = 3;
  localparam int IDX_MES    = 4;
  localparam int IDX_ANIO   = 5;
  localparam int IDX_CSEG   = 6;
  localparam int IDX_CMIN   = 7;
  localparam int IDX_CHORA  = 8;

  // True when a nibble is a legal decimal digit.
  function automatic logic is_bcd_digit(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_display_feeder_if.sv
// Digit-display write port: byte, position and a one-cycle write strobe.
interface rtc_display_feeder_if;
  logic [7:0] DIR_DATO;
  logic [3:0] POSICION;
  logic       RD;

  modport master (output DIR_DATO, output POSICION, output RD);
  modport slave  (input  DIR_DATO, input  POSICION, input  RD);
endinterface

// File: rtl/bcd_check.sv
// Combinational packed-BCD validator: flags a byte with any nibble above 9
// and substitutes the blank value for it.
module bcd_check
  import display_pkg::*;
(
  input  logic [7:0] din,
  output logic       valid,
  output logic [7:0] dout
);

  assign valid = is_bcd_digit(din[7:4]) && is_bcd_digit(din[3:0]);
  assign dout  = valid ? din : BCD_BLANK;

endmodule

// File: rtl/rtc_display_feeder.sv
// Snapshots the BCD time/date/chronometer bytes at each V_Sync falling edge
// and replays them to the display one entry at a time, so the visible digits
// only change during vertical blanking.
module rtc_display_feeder
  import display_pkg::*;
#(
  parameter int N_REG = N_REG_DEF,
  parameter int GAP   = 2
) (
  input  logic                 reloj,
  input  logic                 resetM,
  input  logic                 V_Sync,
  input  logic                 ENABLE,
  input  logic [8*N_REG-1:0]   DATOS_IN,
  rtc_display_feeder_if.master disp,
  output logic                 OCUPADO,
  output logic                 ERROR_BCD,
  output logic                 OVERRUN
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [3:0]    K_LAST   = 4'(N_REG - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  // Snapshot is sized for the largest legal N_REG; unused slots stay zero.
  logic [7:0]    snap_reg [16];
  logic          load_snap;

  logic          vs_q;
  logic          frame_edge;

  state_t        state_reg, state_next;
  logic [3:0]    k_reg, k_next;
  logic [3:0]    k_inc;
  logic [GW-1:0] gap_reg, gap_next;

  // Set when the FSM enters PRESENTA next cycle; the output byte is
  // registered at that transition so it is valid throughout PRESENTA.
  logic          present;
  logic [7:0]    chk_in;
  logic          chk_valid;
  logic [7:0]    chk_data;

  logic [7:0]    dir_reg;
  logic [3:0]    pos_reg;
  logic          rd_reg;
  logic          ocu_reg;
  logic          err_reg;
  logic          ovr_reg;

  assign frame_edge = vs_q & ~V_Sync;
  assign k_inc      = k_reg + 4'd1;

  // Per-entry snapshot registers, loaded together at the frame edge
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_snap
      if (gi < N_REG) begin : g_used
        always_ff @(posedge reloj) begin
          if (resetM) begin
            snap_reg[gi] <= 8'h00;
          end else if (load_snap) begin
            snap_reg[gi] <= DATOS_IN[8*gi +: 8];
          end
        end
      end else begin : g_unused
        always_ff @(posedge reloj) begin
          snap_reg[gi] <= 8'h00;
        end
      end
    end
  endgenerate

  bcd_check u_bcd_check (
    .din   (chk_in),
    .valid (chk_valid),
    .dout  (chk_data)
  );

  // Next-state logic and selection of the byte about to be presented
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    gap_next   = gap_reg;
    load_snap  = 1'b0;
    present    = 1'b0;
    chk_in     = snap_reg[k_reg];

    unique case (state_reg)
      IDLE: begin
        if (frame_edge && ENABLE) begin
          load_snap  = 1'b1;
          present    = 1'b1;
          k_next     = 4'd0;
          // Snapshot is not loaded yet, so entry 0 comes straight from the input.
          chk_in     = DATOS_IN[7:0];
          state_next = PRESENTA;
        end
      end
      PRESENTA: begin
        state_next = STROBE;
      end
      STROBE: begin
        gap_next   = GAP_LOAD;
        state_next = ESPERA;
      end
      ESPERA: begin
        if (gap_reg == '0) begin
          if (k_reg == K_LAST) begin
            state_next = IDLE;
          end else begin
            k_next     = k_inc;
            present    = 1'b1;
            chk_in     = snap_reg[k_inc];
            state_next = PRESENTA;
          end
        end else begin
          gap_next = gap_reg - GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and V_Sync delay register
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_reg <= IDLE;
      k_reg     <= 4'd0;
      gap_reg   <= '0;
      vs_q      <= 1'b1;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      gap_reg   <= gap_next;
      vs_q      <= V_Sync;
    end
  end

  // Registered outputs, all derived from the upcoming state
  always_ff @(posedge reloj) begin
    if (resetM) begin
      dir_reg <= 8'h00;
      pos_reg <= 4'd0;
      rd_reg  <= 1'b0;
      ocu_reg <= 1'b0;
      err_reg <= 1'b0;
      ovr_reg <= 1'b0;
    end else begin
      rd_reg  <= (state_reg == PRESENTA);
      ocu_reg <= (state_next != IDLE);
      ovr_reg <= frame_edge && (state_reg != IDLE);
      if (present) begin
        dir_reg <= chk_data;
        pos_reg <= k_next;
      end
      if (load_snap) begin
        err_reg <= ~chk_valid;
      end else if (present && !chk_valid) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign disp.DIR_DATO = dir_reg;
  assign disp.POSICION = pos_reg;
  assign disp.RD       = rd_reg;
  assign OCUPADO       = ocu_reg;
  assign ERROR_BCD     = err_reg;
  assign OVERRUN       = ovr_reg;

endmodule

// File: doc/rtc_display_feeder.md
# rtc_display_feeder

Producer side of the digit-display port of the VGA block. It snapshots the nine BCD time/date/chronometer registers at the start of each frame (V_Sync falling edge) and replays them one at a time on DIR_DATO/POSICION, with a one-cycle RD strobe for each. Because updates happen only during vertical blanking, the screen shows no digit tearing. It sits between the RTC register file and the VGA top, and shares `reloj`/`resetM` with them.

## Interface
- N_REG, 9: number of entries per scan (POSICION 0..N_REG-1); must be ≤16.
- GAP, 2: idle cycles after each RD pulse, with data held (≥1).
- reloj  in  1  system clock, all logic on rising edge.
- resetM  in  1  synchronous, active-high reset.
- V_Sync  in  1  VGA vertical sync, active low, synchronous to reloj.
- ENABLE  in  1  when 0, new scans are not started; a scan in progress completes.
- DATOS_IN  in  8*N_REG  packed BCD bytes; entry k = DATOS_IN[8k+7:8k] (0 seg, 1 min, 2 hora, 3 dia, 4 mes, 5 anio, 6 crono seg, 7 crono min, 8 crono hora).
- DIR_DATO  out  8  BCD byte for the current POSICION.
- POSICION  out  4  entry index being presented.
- RD  out  1  one-cycle write strobe to the display.
- OCUPADO  out  1  high from snapshot until the scan ends.
- ERROR_BCD  out  1  sticky flag: some entry of the current snapshot had a nibble >9.
- OVERRUN  out  1  one-cycle pulse: a frame edge arrived while OCUPADO=1.

## Operation
- Frame edge: vs_q registers V_Sync; edge = vs_q & ~V_Sync. vs_q resets to 1.
- FSM states: IDLE, PRESENTA, STROBE, ESPERA.
- IDLE: if edge & ENABLE → snapshot DATOS_IN into an internal copy, set k=0, clear ERROR_BCD, go to PRESENTA.
- PRESENTA: drive DIR_DATO = sanitized snapshot[k] and POSICION = k; RD=0. Next state STROBE.
- STROBE: RD=1, data unchanged. Next state ESPERA, with gap counter = GAP-1.
- ESPERA: RD=0, data held. Count down; at 0, if k=N_REG-1 go to IDLE, otherwise k←k+1 and go to PRESENTA.
- Sanitizing: if either nibble of snapshot[k] is >9, output 8'h00 and set ERROR_BCD at that PRESENTA cycle. ERROR_BCD stays set until the next snapshot.
- Edge seen in any state other than IDLE: OVERRUN=1 for one cycle. The edge is dropped and the scan continues.
- Edge with ENABLE=0: ignored, no OVERRUN.
- DIR_DATO/POSICION keep their last values in IDLE.

## Timing
- Reset values: DIR_DATO=8'h00, POSICION=0, RD=0, OCUPADO=0, ERROR_BCD=0, OVERRUN=0, state IDLE, k=0.
- Reset mid-scan: at the next clock edge all outputs return to their reset values. No partial RD is issued.
- Edge detected in cycle t → snapshot and OCUPADO=1 at edge t+1; first PRESENTA data valid in cycle t+1; RD high in cycle t+2.
- Each entry takes 2+GAP cycles. A full scan takes N_REG*(2+GAP) cycles (36 at defaults). OCUPADO drops in the cycle after the last ESPERA.
- DIR_DATO/POSICION are stable one cycle before, during, and GAP cycles after each RD.
- All outputs are registered. There are no combinational paths from input to output.
- DATOS_IN may change at any time; only the value sampled at the snapshot edge is used.

## Structure
- Shared package `display_pkg`: state encoding (2-bit localparams), entry index constants (IDX_SEG … IDX_CHORA), N_REG default, BCD_BLANK = 8'h00.
- One sub-module, `bcd_check`: a combinational 8-bit validator giving valid and sanitized byte outputs. Reusable by the RTC write path.
- Top level holds the edge detector, snapshot register, FSM, and k/gap counters.

## Test plan
- Reset then one V_Sync falling edge, DATOS_IN = {8'h12,8'h34,8'h56,8'h24,8'h07,8'h19,8'h05,8'h30,8'h45} (entry 8 … 0) → 9 RD pulses, POSICION 0..8 carrying 45,30,05,19,07,24,56,34,12. RD at t+2, t+6, …, t+34. OCUPADO high for 36 cycles.
- Entry 3 = 8'h3A, others valid → POSICION 3 outputs 8'h00. ERROR_BCD rises in that PRESENTA cycle and clears at the next frame snapshot.
- Second V_Sync edge 10 cycles into a scan → OVERRUN pulses once; the scan still finishes all 9 entries with the original data.
- DATOS_IN changed mid-scan → outputs still show snapshot values. The new values appear on the next frame.
- ENABLE=0 during an edge → no RD, no OVERRUN. ENABLE dropped mid-scan → scan completes.
- resetM asserted during the STROBE of entry 4 → RD=0 and all outputs at reset values on the next edge. No further RD until a new V_Sync edge.
